// File: rtl/pulse_transmitter_multi_timer_pkg.sv
// Shared definitions for the multi-channel pulse timer.
// - ch_state_t: per-channel run state (IDLE / RUN).
// - prescaler_field_w(): width of one channel's prescaler shift field.
package pulse_transmitter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_t;

  // A shift field must hold 0..PRESCALER_WIDTH-1. Never narrower than one bit.
  function automatic int prescaler_field_w(input int prescaler_width);
    return (prescaler_width > 1) ? $clog2(prescaler_width) : 1;
  endfunction

endpackage

// File: rtl/pulse_transmitter_multi_timer_if.sv
// Control/status bundle between the transmitter control registers (master) and
// the timer block (slave).
// Signals:
//   start, stop   - per-channel 1-cycle strobes
//   prescaler     - per-channel shift field, channel i at slice i
//   duration      - per-channel duration field
//   count         - per-channel pulse count, 0 = unbounded
//   pulse_out     - per-channel 1-cycle pulse per period
//   busy          - per-channel running flag
//   done          - per-channel strobe coincident with the last bounded pulse
interface pulse_transmitter_multi_timer_if
  import pulse_transmitter_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int PRESCALER_WIDTH = 16,
  parameter int TIMER_WIDTH     = 8,
  parameter int COUNT_WIDTH     = 8
) ();

  localparam int PSW = prescaler_field_w(PRESCALER_WIDTH);

  logic [NUM_CH-1:0]             start;
  logic [NUM_CH-1:0]             stop;
  logic [NUM_CH*PSW-1:0]         prescaler;
  logic [NUM_CH*TIMER_WIDTH-1:0] duration;
  logic [NUM_CH*COUNT_WIDTH-1:0] count;
  logic [NUM_CH-1:0]             pulse_out;
  logic [NUM_CH-1:0]             busy;
  logic [NUM_CH-1:0]             done;

  modport master (
    output start, stop, prescaler, duration, count,
    input  pulse_out, busy, done
  );

  modport slave (
    input  start, stop, prescaler, duration, count,
    output pulse_out, busy, done
  );

endinterface

// File: rtl/pulse_transmitter_multi_timer_timer_channel.sv
// One independent timer channel: generates a 1-cycle pulse every
// P = (duration+1) << prescaler cycles, optionally stopping after count pulses.
// Ports:
//   clk, sys_rst_n  - clock, asynchronous active-low reset
//   start_i, stop_i - 1-cycle strobes (stop wins when both are high)
//   prescaler_i     - shift amount; resampled at every pulse edge
//   duration_i      - duration; resampled at every pulse edge
//   count_i         - pulses to emit, 0 = unbounded; sampled at start only
//   pulse_o, busy_o, done_o - registered status outputs
module pulse_transmitter_timer_channel
  import pulse_transmitter_pkg::*;
#(
  parameter int PRESCALER_WIDTH = 16,
  parameter int TIMER_WIDTH     = 8,
  parameter int COUNT_WIDTH     = 8,
  parameter int PSW             = prescaler_field_w(PRESCALER_WIDTH)
) (
  input  logic                   clk,
  input  logic                   sys_rst_n,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [PSW-1:0]         prescaler_i,
  input  logic [TIMER_WIDTH-1:0] duration_i,
  input  logic [COUNT_WIDTH-1:0] count_i,
  output logic                   pulse_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam logic [PRESCALER_WIDTH-1:0] PRE_ONE = PRESCALER_WIDTH'(1);
  localparam logic [TIMER_WIDTH-1:0]     DUR_ONE = TIMER_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0]     REM_ONE = COUNT_WIDTH'(1);

  ch_state_t                state_q;
  logic [PRESCALER_WIDTH-1:0] pre_q;     // prescale countdown
  logic [PRESCALER_WIDTH-1:0] pre_rl_q;  // prescale reload for the current interval
  logic [TIMER_WIDTH-1:0]     dur_q;     // duration countdown
  logic [COUNT_WIDTH-1:0]     rem_q;     // pulses left; 0 means unbounded
  logic                       pulse_q;
  logic                       busy_q;
  logic                       done_q;

  logic [PRESCALER_WIDTH-1:0] pre_rl_d;
  logic                       expire_d;

  assign pre_rl_d = (PRE_ONE << prescaler_i) - PRE_ONE;
  // Both counters exhausted: this edge is a pulse edge.
  assign expire_d = (state_q == ST_RUN) && (pre_q == '0) && (dur_q == '0);

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      pre_q    <= '0;
      pre_rl_q <= '0;
      dur_q    <= '0;
      rem_q    <= '0;
      pulse_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      if (stop_i) begin
        // Abort suppresses any pulse due on this edge.
        state_q  <= ST_IDLE;
        busy_q   <= 1'b0;
        pre_q    <= '0;
        pre_rl_q <= '0;
        dur_q    <= '0;
        rem_q    <= '0;
      end else if (expire_d) begin
        // Pulse edge: emit, then reload from freshly sampled config.
        pulse_q  <= 1'b1;
        pre_q    <= pre_rl_d;
        pre_rl_q <= pre_rl_d;
        dur_q    <= duration_i;
        if (rem_q == REM_ONE) done_q <= 1'b1;
        if (start_i) begin
          rem_q <= count_i;
        end else if (rem_q == REM_ONE) begin
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
          pre_q    <= '0;
          pre_rl_q <= '0;
          dur_q    <= '0;
          rem_q    <= '0;
        end else if (rem_q != '0) begin
          rem_q <= rem_q - REM_ONE;
        end
      end else if (start_i) begin
        // Start or restart: the aborted interval never produces a pulse.
        state_q  <= ST_RUN;
        busy_q   <= 1'b1;
        pre_q    <= pre_rl_d;
        pre_rl_q <= pre_rl_d;
        dur_q    <= duration_i;
        rem_q    <= count_i;
      end else if (state_q == ST_RUN) begin
        if (pre_q == '0) begin
          pre_q <= pre_rl_q;
          dur_q <= dur_q - DUR_ONE;
        end else begin
          pre_q <= pre_q - PRE_ONE;
        end
      end
    end
  end

  assign pulse_o = pulse_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: rtl/pulse_transmitter_multi_timer.sv
// Multi-channel pulse timer: NUM_CH independent channels, each producing
// exact-period 1-cycle pulses with busy/done status.
// Ports:
//   clk        - system clock
//   sys_rst_n  - asynchronous active-low reset
//   bus        - slave side of the control/status interface
module pulse_transmitter_multi_timer
  import pulse_transmitter_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int PRESCALER_WIDTH = 16,
  parameter int TIMER_WIDTH     = 8,
  parameter int COUNT_WIDTH     = 8
) (
  input logic                            clk,
  input logic                            sys_rst_n,
  pulse_transmitter_multi_timer_if.slave bus
);

  localparam int PSW = prescaler_field_w(PRESCALER_WIDTH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pulse_transmitter_timer_channel #(
      .PRESCALER_WIDTH (PRESCALER_WIDTH),
      .TIMER_WIDTH     (TIMER_WIDTH),
      .COUNT_WIDTH     (COUNT_WIDTH),
      .PSW             (PSW)
    ) u_ch (
      .clk         (clk),
      .sys_rst_n   (sys_rst_n),
      .start_i     (bus.start[i]),
      .stop_i      (bus.stop[i]),
      .prescaler_i (bus.prescaler[i*PSW +: PSW]),
      .duration_i  (bus.duration[i*TIMER_WIDTH +: TIMER_WIDTH]),
      .count_i     (bus.count[i*COUNT_WIDTH +: COUNT_WIDTH]),
      .pulse_o     (bus.pulse_out[i]),
      .busy_o      (bus.busy[i]),
      .done_o      (bus.done[i])
    );
  end

endmodule

// File: tb/tb_pulse_transmitter_multi_timer.sv
module tb_pulse_transmitter_multi_timer;
  import pulse_transmitter_pkg::*;

  localparam int NUM_CH          = 2;
  localparam int PRESCALER_WIDTH = 16;
  localparam int TIMER_WIDTH     = 8;
  localparam int COUNT_WIDTH     = 8;
  localparam int PSW             = prescaler_field_w(PRESCALER_WIDTH);

  logic clk = 1'b0;
  logic sys_rst_n;
  always #5 clk = ~clk;

  pulse_transmitter_multi_timer_if #(
    .NUM_CH(NUM_CH), .PRESCALER_WIDTH(PRESCALER_WIDTH),
    .TIMER_WIDTH(TIMER_WIDTH), .COUNT_WIDTH(COUNT_WIDTH)
  ) bus ();

  pulse_transmitter_multi_timer #(
    .NUM_CH(NUM_CH), .PRESCALER_WIDTH(PRESCALER_WIDTH),
    .TIMER_WIDTH(TIMER_WIDTH), .COUNT_WIDTH(COUNT_WIDTH)
  ) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .bus(bus)
  );

  logic [NUM_CH-1:0]      start_v, stop_v;
  logic [PSW-1:0]         ps_v  [NUM_CH];
  logic [TIMER_WIDTH-1:0] dur_v [NUM_CH];
  logic [COUNT_WIDTH-1:0] cnt_v [NUM_CH];

  logic [NUM_CH*PSW-1:0]         ps_pk;
  logic [NUM_CH*TIMER_WIDTH-1:0] dur_pk;
  logic [NUM_CH*COUNT_WIDTH-1:0] cnt_pk;

  always_comb begin
    ps_pk  = '0;
    dur_pk = '0;
    cnt_pk = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ps_pk[c*PSW +: PSW]                 = ps_v[c];
      dur_pk[c*TIMER_WIDTH +: TIMER_WIDTH] = dur_v[c];
      cnt_pk[c*COUNT_WIDTH +: COUNT_WIDTH] = cnt_v[c];
    end
  end

  assign bus.start     = start_v;
  assign bus.stop      = stop_v;
  assign bus.prescaler = ps_pk;
  assign bus.duration  = dur_pk;
  assign bus.count     = cnt_pk;

  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;

  // Reference model: absolute time of the next pulse per channel.
  bit     m_run  [NUM_CH];
  longint m_next [NUM_CH];
  int     m_rem  [NUM_CH];
  bit     m_bnd  [NUM_CH];
  bit     e_pulse[NUM_CH];
  bit     e_done [NUM_CH];

  // Recording of one channel relative to a start edge t0.
  int     rec_ch = 0;
  longint t0 = 0;
  int     r_np, r_first, r_done, r_busyend;
  int     pedges[$];

  function automatic longint period(int c);
    return longint'(int'(dur_v[c]) + 1) << ps_v[c];
  endfunction

  task automatic check(string name, longint got, longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_run[c] = 0; m_next[c] = 0; m_rem[c] = 0; m_bnd[c] = 0;
      e_pulse[c] = 0; e_done[c] = 0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < NUM_CH; c++) begin
      e_pulse[c] = 0;
      e_done[c]  = 0;
      if (stop_v[c]) begin
        m_run[c] = 0;
      end else begin
        if (m_run[c] && cyc == m_next[c]) begin
          e_pulse[c] = 1;
          m_next[c]  = cyc + period(c);
          if (m_bnd[c]) begin
            m_rem[c]--;
            if (m_rem[c] == 0) begin
              e_done[c] = 1;
              m_run[c]  = 0;
            end
          end
        end
        if (start_v[c]) begin
          m_run[c]  = 1;
          m_next[c] = cyc + period(c);
          m_rem[c]  = int'(cnt_v[c]);
          m_bnd[c]  = (cnt_v[c] != 0);
        end
      end
    end
  endtask

  task automatic begin_rec(int c);
    rec_ch = c; t0 = cyc;
    r_np = 0; r_first = 0; r_done = 0; r_busyend = 0;
    pedges.delete();
  endtask

  // One clock edge: advance model with the inputs sampled there, then compare.
  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      check($sformatf("pulse%0d", c), longint'(bus.pulse_out[c]), longint'(e_pulse[c]));
      check($sformatf("busy%0d", c),  longint'(bus.busy[c]),      longint'(m_run[c]));
      check($sformatf("done%0d", c),  longint'(bus.done[c]),      longint'(e_done[c]));
    end
    if (bus.pulse_out[rec_ch] === 1'b1) begin
      r_np++;
      if (r_first == 0) r_first = int'(cyc - t0);
      pedges.push_back(int'(cyc - t0));
    end
    if (bus.done[rec_ch] === 1'b1) r_done = int'(cyc - t0);
    if (bus.busy[rec_ch] === 1'b0 && r_busyend == 0) r_busyend = int'(cyc - t0);
  endtask

  task automatic start_ch(int c, int ps, int dur, int cnt);
    ps_v[c] = PSW'(ps); dur_v[c] = TIMER_WIDTH'(dur); cnt_v[c] = COUNT_WIDTH'(cnt);
    start_v[c] = 1'b1;
    step();
    start_v = '0;
  endtask

  task automatic stop_all();
    stop_v = '1;
    step();
    stop_v = '0;
    step();
  endtask

  typedef struct {
    int ch; int ps; int dur; int cnt; int run;
    int first; int np; int done_e; int busy_end;
  } vec_t;

  vec_t tbl[6];

  initial begin
    sys_rst_n = 1'b0;
    start_v = '0; stop_v = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ps_v[c] = '0; dur_v[c] = '0; cnt_v[c] = '0;
    end
    model_reset();

    #12;
    check("rst_pulse", longint'(bus.pulse_out), 0);
    check("rst_busy",  longint'(bus.busy), 0);
    check("rst_done",  longint'(bus.done), 0);
    repeat (2) @(posedge clk);
    #3 sys_rst_n = 1'b1;

    // ch, ps, dur, cnt, run, first, np, done edge, busy-fall edge
    tbl[0] = '{0, 0, 3, 0, 13, 4, 3, 0, 0};
    tbl[1] = '{1, 2, 1, 3, 30, 8, 3, 24, 24};
    tbl[2] = '{0, 0, 0, 0, 9, 1, 9, 0, 0};
    tbl[3] = '{1, 1, 4, 2, 30, 10, 2, 20, 20};
    tbl[4] = '{0, 0, 0, 1, 5, 1, 1, 1, 1};
    tbl[5] = '{1, 3, 0, 0, 20, 8, 2, 0, 0};

    for (int i = 0; i < 6; i++) begin
      start_ch(tbl[i].ch, tbl[i].ps, tbl[i].dur, tbl[i].cnt);
      begin_rec(tbl[i].ch);
      repeat (tbl[i].run) step();
      check($sformatf("t%0d_first", i),   r_first,   tbl[i].first);
      check($sformatf("t%0d_np", i),      r_np,      tbl[i].np);
      check($sformatf("t%0d_done", i),    r_done,    tbl[i].done_e);
      check($sformatf("t%0d_busyend", i), r_busyend, tbl[i].busy_end);
      stop_all();
    end

    // P=1 continuous, stop at edge 10.
    start_ch(0, 0, 0, 0);
    begin_rec(0);
    repeat (9) step();
    stop_v[0] = 1'b1;
    step();
    stop_v = '0;
    check("stop_np", r_np, 9);
    check("stop_pulse", longint'(bus.pulse_out[0]), 0);
    check("stop_busy", longint'(bus.busy[0]), 0);
    repeat (3) step();

    // Restart at edge 7 with P=10: first pulse at 17.
    start_ch(0, 1, 4, 0);
    begin_rec(0);
    repeat (6) step();
    start_v[0] = 1'b1;
    step();
    start_v = '0;
    repeat (13) step();
    check("restart_first", r_first, 17);
    check("restart_np", r_np, 1);

    // start+stop together while running: idle, no pulses.
    start_v[0] = 1'b1; stop_v[0] = 1'b1;
    step();
    start_v = '0; stop_v = '0;
    begin_rec(0);
    repeat (12) step();
    check("ss_np", r_np, 0);
    check("ss_busy", longint'(bus.busy[0]), 0);

    // Duration 3 -> 1 from edge 2: pulses at 4, 6, 8.
    start_ch(0, 0, 3, 0);
    begin_rec(0);
    step();
    dur_v[0] = 1;
    repeat (8) step();
    check("dchg_n", pedges.size(), 3);
    if (pedges.size() >= 3) begin
      check("dchg_p0", pedges[0], 4);
      check("dchg_p1", pedges[1], 6);
      check("dchg_p2", pedges[2], 8);
    end
    stop_all();

    // Asynchronous reset mid-period on both channels.
    start_v = '1;
    ps_v[0] = 0; dur_v[0] = 5; cnt_v[0] = 0;
    ps_v[1] = 1; dur_v[1] = 2; cnt_v[1] = 0;
    step();
    start_v = '0;
    repeat (4) step();
    #2 sys_rst_n = 1'b0;
    #1;
    check("arst_pulse", longint'(bus.pulse_out), 0);
    check("arst_busy",  longint'(bus.busy), 0);
    check("arst_done",  longint'(bus.done), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #3 sys_rst_n = 1'b1;
    begin_rec(1);
    repeat (20) step();
    check("arst_np", r_np, 0);

    // Random traffic on all channels against the model.
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        ps_v[c]    = PSW'($urandom_range(0, 2));
        dur_v[c]   = TIMER_WIDTH'($urandom_range(0, 5));
        cnt_v[c]   = COUNT_WIDTH'($urandom_range(0, 3));
        start_v[c] = ($urandom_range(0, 15) == 0);
        stop_v[c]  = ($urandom_range(0, 39) == 0);
      end
      step();
    end
    start_v = '0;
    stop_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
